// File: rtl/puf_pkg.sv
// Shared types and helpers for the PUF readout engine: FSM states,
// default command bytes and word/lane arithmetic.
package puf_pkg;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_MEM_WAIT,
    ST_LOAD,
    ST_WAIT_RDY,
    ST_SEND,
    ST_WAIT_TX,
    ST_NEXT,
    ST_CSUM
  } state_e;

  localparam logic [7:0] CMD_FULL_DEF  = 8'h73;
  localparam logic [7:0] CMD_RANGE_DEF = 8'h72;
  localparam logic [7:0] CMD_ABORT_DEF = 8'h78;
  localparam int         NUM_ARGS      = 4;

  function automatic int bpw_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lane_of(input int idx, input int bpw);
    return idx % bpw;
  endfunction

endpackage

// File: rtl/puf_cmd_parser.sv
// Command byte decoder: recognises full/ranged dump requests while idle,
// collects the four ranged-dump argument bytes, and flags aborts while busy.
module puf_cmd_parser
  import puf_pkg::*;
#(
  parameter int         NUM_BYTES = 16384,
  parameter logic [7:0] CMD_FULL  = CMD_FULL_DEF,
  parameter logic [7:0] CMD_RANGE = CMD_RANGE_DEF,
  parameter logic [7:0] CMD_ABORT = CMD_ABORT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        idle_i,
  input  logic        busy_i,
  input  logic        rx_vld_i,
  input  logic [7:0]  rx_data_i,
  output logic        cmd_vld_o,
  output logic [15:0] start_o,
  output logic [16:0] len_o,
  output logic        abort_o
);

  logic        arg_q,  arg_d;
  logic [1:0]  cnt_q,  cnt_d;
  logic [23:0] args_q, args_d;

  // Outputs are combinational so the engine can drive the first address
  // in the very cycle after the command/last argument byte.
  always_comb begin
    arg_d     = arg_q;
    cnt_d     = cnt_q;
    args_d    = args_q;
    cmd_vld_o = 1'b0;
    start_o   = '0;
    len_o     = '0;
    abort_o   = busy_i && rx_vld_i && (rx_data_i == CMD_ABORT);
    if (idle_i && rx_vld_i) begin
      if (arg_q) begin
        if (cnt_q == 2'(NUM_ARGS - 1)) begin
          cmd_vld_o = 1'b1;
          start_o   = args_q[23:8];
          len_o     = {1'b0, args_q[7:0], rx_data_i};
          arg_d     = 1'b0;
          cnt_d     = '0;
        end else begin
          args_d = {args_q[15:0], rx_data_i};
          cnt_d  = cnt_q + 2'd1;
        end
      end else if (rx_data_i == CMD_FULL) begin
        cmd_vld_o = 1'b1;
        len_o     = 17'(NUM_BYTES);
      end else if (rx_data_i == CMD_RANGE) begin
        arg_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arg_q  <= 1'b0;
      cnt_q  <= '0;
      args_q <= '0;
    end else begin
      arg_q  <= arg_d;
      cnt_q  <= cnt_d;
      args_q <= args_d;
    end
  end

endmodule

// File: rtl/puf_dump_engine.sv
// UART-driven PUF readout: streams RAM bytes (full or ranged, wrapping)
// to the transmitter, then an XOR checksum byte; abortable mid-dump.
module puf_dump_engine
  import puf_pkg::*;
#(
  parameter int         DATA_W    = 16,
  parameter int         ADDR_W    = 13,
  parameter int         NUM_BYTES = 16384,
  parameter logic [7:0] CMD_FULL  = CMD_FULL_DEF,
  parameter logic [7:0] CMD_RANGE = CMD_RANGE_DEF,
  parameter logic [7:0] CMD_ABORT = CMD_ABORT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx_ready,
  input  logic [7:0]        uart_data_from_rx,
  input  logic              uart_tx_ready,
  output logic [7:0]        uart_data_to_tx,
  output logic              uart_tx_enable,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              dump_done
);

  localparam int BPW = bpw_of(DATA_W);
  localparam int IW  = $clog2(NUM_BYTES);

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q,   idx_d;
  logic [16:0]       rem_q,   rem_d;
  logic [7:0]        csum_q,  csum_d;
  logic [7:0]        data_q,  data_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              tx_en_q, tx_en_d;
  logic              done_q,  done_d;
  logic              busy_q,  busy_d;
  logic              abort_q, abort_d;
  logic              csph_q,  csph_d;
  logic              ign_q,   ign_d;

  logic              cmd_vld, abort_p;
  logic [15:0]       cmd_start;
  logic [16:0]       cmd_len;
  logic [IW-1:0]     idx_start, idx_nxt;
  logic [7:0]        lane_byte;
  int                lane;

  puf_cmd_parser #(
    .NUM_BYTES (NUM_BYTES),
    .CMD_FULL  (CMD_FULL),
    .CMD_RANGE (CMD_RANGE),
    .CMD_ABORT (CMD_ABORT)
  ) u_parser (
    .clk       (clk),
    .rst_n     (rst_n),
    .idle_i    (state_q == ST_IDLE),
    .busy_i    (busy_q),
    .rx_vld_i  (uart_rx_ready),
    .rx_data_i (uart_data_from_rx),
    .cmd_vld_o (cmd_vld),
    .start_o   (cmd_start),
    .len_o     (cmd_len),
    .abort_o   (abort_p)
  );

  function automatic logic [ADDR_W-1:0] waddr(input logic [IW-1:0] i);
    return ADDR_W'(int'(i) / BPW);
  endfunction

  assign idx_start = IW'(int'(cmd_start) % NUM_BYTES);
  assign idx_nxt   = idx_q + 1'b1;
  assign lane      = lane_of(int'(idx_q), BPW);
  assign lane_byte = 8'(ram_rdata >> (8 * lane));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    csum_d   = csum_q;
    data_d   = data_q;
    raddr_d  = raddr_q;
    tx_en_d  = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    abort_d  = abort_q;
    csph_d   = csph_q;
    ign_d    = ign_q;
    // Abort only matters before the checksum phase starts.
    if (abort_p && busy_q && !csph_q) abort_d = 1'b1;
    case (state_q)
      ST_INIT: begin
        tx_en_d = 1'b1;
        data_d  = 8'h00;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (cmd_vld) begin
          idx_d   = idx_start;
          raddr_d = waddr(idx_start);
          rem_d   = cmd_len;
          csum_d  = 8'h00;
          abort_d = 1'b0;
          csph_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = (cmd_len == '0) ? ST_CSUM : ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: state_d = ST_LOAD;
      ST_LOAD: begin
        data_d  = lane_byte;
        csum_d  = csum_q ^ lane_byte;
        tx_en_d = uart_tx_ready;
        state_d = uart_tx_ready ? ST_SEND : ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        tx_en_d = uart_tx_ready;
        state_d = uart_tx_ready ? ST_SEND : ST_WAIT_RDY;
      end
      ST_SEND: begin
        ign_d   = 1'b1;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        // tx_ready may still reflect the pre-strobe idle state for a cycle.
        if (ign_q) begin
          ign_d = 1'b0;
        end else if (uart_tx_ready) begin
          if (csph_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        rem_d = rem_q - 17'd1;
        if (rem_q == 17'd1 || abort_q) begin
          state_d = ST_CSUM;
        end else begin
          idx_d   = idx_nxt;
          raddr_d = waddr(idx_nxt);
          state_d = ST_MEM_WAIT;
        end
      end
      ST_CSUM: begin
        data_d  = csum_q;
        csph_d  = 1'b1;
        tx_en_d = uart_tx_ready;
        state_d = uart_tx_ready ? ST_SEND : ST_WAIT_RDY;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      rem_q   <= '0;
      csum_q  <= '0;
      data_q  <= '0;
      raddr_q <= '0;
      tx_en_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
      csph_q  <= 1'b0;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
      raddr_q <= raddr_d;
      tx_en_q <= tx_en_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      abort_q <= abort_d;
      csph_q  <= csph_d;
      ign_q   <= ign_d;
    end
  end

  assign uart_data_to_tx = data_q;
  assign uart_tx_enable  = tx_en_q;
  assign ram_raddr       = raddr_q;
  assign busy            = busy_q;
  assign dump_done       = done_q;

endmodule

// File: tb/tb_puf_dump_engine.sv
// Bench for puf_dump_engine: directed and randomized dumps scored against
// a byte-array reference of the PUF contents and a behavioural transmitter.
module tb_puf_dump_engine;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uart_rx_ready = 1'b0;
  logic [7:0]    uart_data_from_rx = 8'h00;
  logic          uart_tx_ready = 1'b1;
  logic [7:0]    uart_data_to_tx;
  logic          uart_tx_enable;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic          busy;
  logic          dump_done;

  logic [DW-1:0] mem [4];
  logic [7:0]    txq [$];
  bit            bzq [$];
  int            n_chk = 0;
  int            n_err = 0;
  int            done_cnt = 0;
  int            tx_gap = 0;
  int            tx_cnt = 0;
  logic [7:0]    tx_held = 8'h00;

  puf_dump_engine #(.DATA_W(DW), .ADDR_W(AW), .NUM_BYTES(NB)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .uart_rx_ready     (uart_rx_ready),
    .uart_data_from_rx (uart_data_from_rx),
    .uart_tx_ready     (uart_tx_ready),
    .uart_data_to_tx   (uart_data_to_tx),
    .uart_tx_enable    (uart_tx_enable),
    .ram_raddr         (ram_raddr),
    .ram_rdata         (ram_rdata),
    .busy              (busy),
    .dump_done         (dump_done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data follows the address by one clock.
  always @(posedge clk) ram_rdata <= mem[ram_raddr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int i);
    logic [DW-1:0] w;
    w = mem[i / 2];
    return w[8 * (i % 2) +: 8];
  endfunction

  // Transmitter model: accepts a byte on enable, stays busy for a gap.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_cnt        = 0;
        uart_tx_ready = 1'b1;
      end else if (uart_tx_enable) begin
        chk("en_while_tx_busy", 32'(uart_tx_ready), 32'd1);
        tx_held = uart_data_to_tx;
        txq.push_back(uart_data_to_tx);
        bzq.push_back(busy);
        tx_cnt        = (tx_gap > 0) ? tx_gap : int'($urandom_range(1, 4));
        uart_tx_ready = 1'b0;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          chk("tx_data_hold", 32'(uart_data_to_tx), 32'(tx_held));
          uart_tx_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (dump_done) done_cnt++;
    end
  end

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    uart_data_from_rx = b;
    uart_rx_ready     = 1'b1;
    @(negedge clk);
    uart_rx_ready     = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int cyc;
    cyc = 0;
    while (!(txq.size() >= n && uart_tx_ready) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_tx_timeout", 32'(cyc < 300), 32'd1);
  endtask

  // ab > 0: send the abort byte while the ab-th data byte is in flight.
  task automatic run_cmd(input bit full, input logic [15:0] st, input logic [15:0] ln, input int ab);
    logic [7:0] exp_q [$];
    logic [7:0] cs;
    int         s, n, d0, lat, cyc;
    bit         do_ab, allb;
    s     = full ? 0 : int'(st) % NB;
    n     = full ? NB : int'(ln);
    do_ab = (ab > 0) && (ab < n);
    if (do_ab) n = ab;
    cs = 8'h00;
    for (int j = 0; j < n; j++) begin
      exp_q.push_back(byte_at((s + j) % NB));
      cs ^= byte_at((s + j) % NB);
    end
    exp_q.push_back(cs);
    wait_tx(0);
    txq.delete();
    bzq.delete();
    d0 = done_cnt;
    if (full) send_rx(8'h73);
    else begin
      send_rx(8'h72);
      send_rx(st[15:8]);
      send_rx(st[7:0]);
      send_rx(ln[15:8]);
      send_rx(ln[7:0]);
    end
    chk("busy_after_cmd", 32'(busy), 32'd1);
    if (n > 0) begin
      chk("raddr_first", 32'(ram_raddr), 32'(s / 2));
      lat = 0;
      while (!uart_tx_enable && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("first_tx_latency", 32'(lat), 32'd2);
    end
    if (do_ab) begin
      cyc = 0;
      while (txq.size() < ab && cyc < 500) begin
        @(negedge clk);
        cyc++;
      end
      send_rx(8'h78);
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (6) @(negedge clk);
    chk("dump_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("tx_count", 32'(txq.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++)
      chk($sformatf("tx_byte[%0d]", i), 32'(txq[i]), 32'(exp_q[i]));
    allb = 1'b1;
    foreach (bzq[i]) allb &= bzq[i];
    chk("busy_during_tx", 32'(allb), 32'd1);
  endtask

  initial begin
    int cyc;
    logic [15:0] rs, rl;
    mem[0] = 16'hA55A; mem[1] = 16'h1234; mem[2] = 16'hBEEF; mem[3] = 16'h0001;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({uart_tx_enable, uart_data_to_tx, ram_raddr, busy, dump_done}), 32'd0);
    rst_n = 1'b1;
    wait_tx(1);
    chk("init_dummy_count", 32'(txq.size()), 32'd1);
    if (txq.size() > 0) chk("init_dummy_byte", 32'(txq[0]), 32'h00);

    tx_gap = 0;
    run_cmd(1'b0, 16'h0000, 16'h0003, 0);
    run_cmd(1'b1, 16'h0000, 16'h0000, 0);
    run_cmd(1'b0, 16'h0007, 16'h0002, 0);
    run_cmd(1'b0, 16'h0003, 16'h0000, 0);

    txq.delete();
    send_rx(8'h71);
    send_rx(8'h78);
    repeat (20) @(negedge clk);
    chk("unknown_busy", 32'(busy), 32'd0);
    chk("unknown_no_tx", 32'(txq.size()), 32'd0);

    tx_gap = 3;
    run_cmd(1'b1, 16'h0000, 16'h0000, 2);
    tx_gap = 10;
    run_cmd(1'b1, 16'h0000, 16'h0000, 0);

    // Reset in the middle of a slow full dump.
    txq.delete();
    send_rx(8'h73);
    cyc = 0;
    while (txq.size() < 3 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'({uart_tx_enable, uart_data_to_tx, ram_raddr, busy, dump_done}), 32'd0);
    repeat (2) @(negedge clk);
    txq.delete();
    rst_n = 1'b1;
    wait_tx(1);
    chk("midreset_dummy_count", 32'(txq.size()), 32'd1);
    if (txq.size() > 0) chk("midreset_dummy_byte", 32'(txq[0]), 32'h00);
    chk("midreset_busy", 32'(busy), 32'd0);

    for (int t = 0; t < 10; t++) begin
      int ab;
      bit full;
      for (int w = 0; w < 4; w++) mem[w] = DW'($urandom);
      full   = ($urandom_range(0, 3) == 0);
      rs     = 16'($urandom);
      rl     = 16'($urandom_range(0, 20));
      ab     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : 0;
      tx_gap = (ab > 0) ? 3 : 0;
      run_cmd(full, rs, rl, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
